// File: rtl/ethstream_packetizer.sv
// ethstream_packetizer: store-and-forward framer, buffers one byte frame and re-emits it
// as length LSB, length MSB, payload; frames close on tlast, MAX_LEN or input idle timeout.
module ethstream_packetizer #(
   parameter int ADDR_BITS = 11,
   parameter int MAX_LEN   = 1472,
   parameter int TIMEOUT   = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic        s_axis_tlast,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic [15:0] frame_count,
   output logic        split_pulse
);
   localparam int IW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
   localparam logic [15:0] ML = 16'(MAX_LEN);
   localparam logic [IW-1:0] TL = IW'(TIMEOUT - 1);
   typedef enum logic [1:0] {FILL, HDR_LSB, HDR_MSB, DRAIN} state_t;
   state_t state;
   logic [7:0] mem [2**ADDR_BITS];
   logic [7:0] q;
   logic [15:0] cnt, cnt_n, rd;
   logic [ADDR_BITS-1:0] ra;
   logic [IW-1:0] idle;
   logic acc, hs, adv, close, split;
   always_comb begin
      acc   = s_axis_tvalid & s_axis_tready;
      hs    = m_axis_tvalid & m_axis_tready;
      cnt_n = cnt + 16'(acc);
      close = acc ? (s_axis_tlast || cnt_n == ML) : (TIMEOUT != 0 && cnt != 16'd0 && idle == TL);
      split = acc && !s_axis_tlast && cnt_n == ML;
      adv   = hs && (state == HDR_MSB || (state == DRAIN && !m_axis_tlast));
      ra    = rd[ADDR_BITS-1:0] + ADDR_BITS'(adv);
   end
   // q always holds mem[rd], so the next payload byte is ready on every handshake
   always_ff @(posedge clk) begin
      if (acc) mem[cnt[ADDR_BITS-1:0]] <= s_axis_tdata;
      q <= mem[ra];
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= FILL;
         cnt           <= '0;
         rd            <= '0;
         idle          <= '0;
         s_axis_tready <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         frame_count   <= '0;
         split_pulse   <= 1'b0;
      end else begin
         split_pulse <= 1'b0;
         rd          <= rd + 16'(adv);
         case (state)
            FILL: begin
               cnt           <= cnt_n;
               idle          <= acc || close ? '0 : cnt != 16'd0 ? idle + 1'b1 : idle;
               s_axis_tready <= !close;
               if (close) begin
                  state         <= HDR_LSB;
                  m_axis_tvalid <= 1'b1;
                  m_axis_tdata  <= cnt_n[7:0];
                  split_pulse   <= split;
               end
            end
            HDR_LSB: if (hs) begin
               state        <= HDR_MSB;
               m_axis_tdata <= cnt[15:8];
            end
            HDR_MSB: if (hs) begin
               state        <= DRAIN;
               m_axis_tdata <= q;
               m_axis_tlast <= cnt == 16'd1;
            end
            DRAIN: if (hs) begin
               if (m_axis_tlast) begin
                  state         <= FILL;
                  cnt           <= '0;
                  rd            <= '0;
                  m_axis_tvalid <= 1'b0;
                  m_axis_tdata  <= '0;
                  m_axis_tlast  <= 1'b0;
                  frame_count   <= frame_count + 16'd1;
                  s_axis_tready <= 1'b1;
               end else begin
                  m_axis_tdata <= q;
                  m_axis_tlast <= rd == cnt - 16'd1;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ethstream_packetizer.sv
// tb_ethstream_packetizer: random and directed frames checked each cycle against a
// queue-based model of the length-prefixed output stream.
module tb_ethstream_packetizer;
   localparam int MAXL = 300;
   localparam int TOUT = 16;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [7:0] s_axis_tdata = 8'h00;
   logic s_axis_tvalid = 1'b0;
   logic s_axis_tlast = 1'b0;
   logic s_axis_tready;
   logic [7:0] m_axis_tdata;
   logic m_axis_tvalid, m_axis_tlast;
   logic m_axis_tready = 1'b1;
   logic [15:0] frame_count;
   logic split_pulse;
   int checks = 0, errors = 0;
   logic [7:0] fill_q[$], sent[$];
   logic [8:0] out_q[$], got[$], exp_s[$];
   int idle_m = 0, streak = 0, last_streak = 0, split_seen = 0, busy_rdy = 0;
   logic [15:0] fc_m = 16'd0;
   logic started = 1'b0, exp_split = 1'b0, rnd_mode = 1'b0;

   ethstream_packetizer #(.ADDR_BITS(9), .MAX_LEN(MAXL), .TIMEOUT(TOUT)) dut (
      .clk(clk), .reset(reset),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tlast(s_axis_tlast),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .frame_count(frame_count), .split_pulse(split_pulse));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic bound(input string name, input int n, input int lim);
      checks++;
      if (n >= lim) begin
         errors++;
         $display("FAIL %s: waited %0d cycles, limit %0d", name, n, lim);
      end
   endtask

   // a closed frame becomes: len LSB, len MSB, payload with tlast on the final byte
   task automatic emit();
      int len;
      len = fill_q.size();
      out_q.push_back({1'b0, 8'(len)});
      out_q.push_back({1'b0, 8'(len >> 8)});
      foreach (fill_q[i]) out_q.push_back({i == fill_q.size() - 1, fill_q[i]});
      fill_q.delete();
      idle_m = 0;
   endtask

   task automatic send(input logic [7:0] d, input logic l, input int gap);
      int n;
      s_axis_tvalid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      s_axis_tdata = d;
      s_axis_tlast = l;
      s_axis_tvalid = 1'b1;
      n = 0;
      while (!s_axis_tready && n < 3000) begin @(posedge clk); #1; n++; end
      if (n != 0) bound("send_wait", n, 3000);
      @(posedge clk); #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0;
   endtask

   task automatic wait_quiet();
      int n;
      n = 0;
      while ((fill_q.size() != 0 || out_q.size() != 0) && n < 5000) begin @(posedge clk); #1; n++; end
      bound("quiet_wait", n, 5000);
   endtask

   task automatic push_payload(input int s, input int n);
      for (int i = 0; i < n; i++) exp_s.push_back({i == n - 1, sent[s + i]});
   endtask

   task automatic chk_stream(input string name);
      int bad;
      bad = 0;
      chk({name, "_beats"}, 32'(got.size()), 32'(exp_s.size()));
      foreach (exp_s[i]) if (i >= got.size() || got[i] !== exp_s[i]) bad++;
      chk({name, "_bad_beats"}, 32'(bad), 32'd0);
   endtask

   initial forever begin
      @(posedge clk); #1;
      m_axis_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // compare DUT against the model, then advance the model to the coming edge
   initial begin
      logic [8:0] w;
      logic rdy;
      forever begin
         @(negedge clk);
         if (reset) begin
            fill_q.delete();
            out_q.delete();
            idle_m = 0;
            fc_m = 16'd0;
            started = 1'b0;
            exp_split = 1'b0;
            streak = 0;
         end else begin
            chk("s_tready", 32'(s_axis_tready), 32'(started && out_q.size() == 0));
            chk("m_tvalid", 32'(m_axis_tvalid), 32'(out_q.size() != 0));
            if (out_q.size() != 0) begin
               chk("m_tdata", 32'(m_axis_tdata), 32'(out_q[0][7:0]));
               chk("m_tlast", 32'(m_axis_tlast), 32'(out_q[0][8]));
            end
            chk("frame_count", 32'(frame_count), 32'(fc_m));
            chk("split_pulse", 32'(split_pulse), 32'(exp_split));
            if (m_axis_tvalid && m_axis_tready) begin
               got.push_back({m_axis_tlast, m_axis_tdata});
               streak++;
               if (m_axis_tlast) last_streak = streak;
            end else streak = 0;
            if (split_pulse) split_seen++;
            if (m_axis_tvalid && s_axis_tready) busy_rdy++;
            rdy = started && out_q.size() == 0;
            exp_split = 1'b0;
            if (out_q.size() != 0 && m_axis_tready) begin
               w = out_q.pop_front();
               if (w[8]) fc_m = fc_m + 16'd1;
            end
            if (rdy) begin
               if (s_axis_tvalid) begin
                  fill_q.push_back(s_axis_tdata);
                  idle_m = 0;
                  if (s_axis_tlast || fill_q.size() == MAXL) begin
                     exp_split = !s_axis_tlast;
                     emit();
                  end
               end else if (fill_q.size() != 0) begin
                  idle_m++;
                  if (idle_m == TOUT) emit();
               end
            end
            started = 1'b1;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, s0, len, gap;
      logic wl;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("rst_m_tdata", 32'(m_axis_tdata), 32'd0);
      chk("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
      chk("rst_s_tready", 32'(s_axis_tready), 32'd0);
      chk("rst_frame_count", 32'(frame_count), 32'd0);
      chk("rst_split", 32'(split_pulse), 32'd0);
      reset = 1'b0;
      // four bytes closed by tlast
      got.delete();
      send(8'h11, 1'b0, 0);
      send(8'h12, 1'b0, 0);
      send(8'h13, 1'b0, 0);
      send(8'h14, 1'b1, 0);
      wait_quiet();
      exp_s = '{9'h004, 9'h000, 9'h011, 9'h012, 9'h013, 9'h114};
      chk_stream("t1");
      chk("t1_frame_count", 32'(frame_count), 32'd1);
      // 310 bytes: split at MAX_LEN then a 10-byte remainder
      got.delete();
      sent.delete();
      s0 = split_seen;
      for (int i = 0; i < 310; i++) begin
         sent.push_back(8'($urandom));
         send(sent[i], i == 309, 0);
      end
      wait_quiet();
      exp_s = '{9'h02C, 9'h001};
      push_payload(0, 300);
      exp_s.push_back(9'h00A);
      exp_s.push_back(9'h000);
      push_payload(300, 10);
      chk_stream("t2");
      chk("t2_split_count", 32'(split_seen - s0), 32'd1);
      chk("t2_frame_count", 32'(frame_count), 32'd3);
      // three bytes then idle until the timeout closes the frame
      got.delete();
      sent.delete();
      for (int i = 0; i < 3; i++) begin
         sent.push_back(8'($urandom));
         send(sent[i], 1'b0, 0);
      end
      n = 0;
      while (!m_axis_tvalid && n < 100) begin @(posedge clk); #1; n++; end
      chk("t3_close_delay", 32'(n), 32'd16);
      wait_quiet();
      exp_s = '{9'h003, 9'h000};
      push_payload(0, 3);
      chk_stream("t3");
      chk("t3_frame_count", 32'(frame_count), 32'd4);
      // 300 bytes with tlast exactly at MAX_LEN, random backpressure
      got.delete();
      sent.delete();
      s0 = split_seen;
      busy_rdy = 0;
      rnd_mode = 1'b1;
      for (int i = 0; i < 300; i++) begin
         sent.push_back(8'($urandom));
         send(sent[i], i == 299, 0);
      end
      wait_quiet();
      rnd_mode = 1'b0;
      exp_s = '{9'h02C, 9'h001};
      push_payload(0, 300);
      chk_stream("t4");
      chk("t4_split_count", 32'(split_seen - s0), 32'd0);
      chk("t4_ready_while_busy", 32'(busy_rdy), 32'd0);
      chk("t4_frame_count", 32'(frame_count), 32'd5);
      // max frame with ready held high: no bubbles from header to tlast
      got.delete();
      sent.delete();
      repeat (2) begin @(posedge clk); #1; end
      for (int i = 0; i < 300; i++) begin
         sent.push_back(8'($urandom));
         send(sent[i], i == 299, 0);
      end
      wait_quiet();
      exp_s = '{9'h02C, 9'h001};
      push_payload(0, 300);
      chk_stream("t6");
      chk("t6_consecutive_beats", 32'(last_streak), 32'd302);
      chk("t6_frame_count", 32'(frame_count), 32'd6);
      // random frames, gaps and backpressure against the model
      rnd_mode = 1'b1;
      for (int f = 0; f < 8; f++) begin
         len = int'($urandom_range(1, 340));
         wl = $urandom_range(0, 3) != 0;
         for (int i = 0; i < len; i++) begin
            gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 20)) : 0;
            send(8'($urandom), wl && i == len - 1, gap);
         end
      end
      wait_quiet();
      rnd_mode = 1'b0;
      // reset in the middle of draining the second frame
      send(8'h77, 1'b1, 0);
      wait_quiet();
      for (int i = 0; i < 20; i++) send(8'(i), i == 19, 0);
      repeat (6) begin @(posedge clk); #1; end
      chk("t5_pre_reset_valid", 32'(m_axis_tvalid), 32'd1);
      reset = 1'b1;
      #1;
      chk("t5_rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("t5_rst_m_tdata", 32'(m_axis_tdata), 32'd0);
      chk("t5_rst_m_tlast", 32'(m_axis_tlast), 32'd0);
      chk("t5_rst_s_tready", 32'(s_axis_tready), 32'd0);
      chk("t5_rst_frame_count", 32'(frame_count), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      got.delete();
      send(8'h5A, 1'b1, 0);
      wait_quiet();
      exp_s = '{9'h001, 9'h000, 9'h15A};
      chk_stream("t5");
      chk("t5_frame_count", 32'(frame_count), 32'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
